requant_int8: RTL and testbench

- Pipelined requantization stage that sits directly upstream of the int8 tanh LUT activation.
- Takes a signed 32-bit MAC accumulator, adds bias, multiplies by a fixed-point scale, then arithmetic-right-shifts with rounding and saturates to int8.
- The int8 output feeds the activation LUT input directly.
- Carries a valid/ready handshake and a saturation-event counter for debug.

---
 rtl/cnn_pkg.sv | 10 +
 rtl/round_sat_int8.sv | 41 ++++
 rtl/requant_int8.sv | 101 ++++++++++
 tb/tb_requant_int8.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants for the int8 CNN datapath blocks.
// Used by the requantization stage and its round/saturate helper.
package cnn_pkg;

  localparam int ACC_WIDTH  = 32;
  localparam int DATA_WIDTH = 8;
  localparam int INT8_MAX   = 127;
  localparam int INT8_MIN   = -128;

endpackage

// File: rtl/round_sat_int8.sv
// Combinational round-half-up arithmetic right shift followed by int8 saturation.
// Reusable by any quantizing stage that needs shift-round-clip to int8.
module round_sat_int8
  import cnn_pkg::*;
#(
  parameter int IN_WIDTH    = 49,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [IN_WIDTH-1:0]    val,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  output logic signed [DATA_WIDTH-1:0]  q,
  output logic                          sat
);

  // One guard bit so adding the rounding constant can never overflow.
  localparam int EW = IN_WIDTH + 1;
  localparam logic signed [EW-1:0] RMAX = EW'(INT8_MAX);
  localparam logic signed [EW-1:0] RMIN = EW'(INT8_MIN);

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic        [EW-1:0] one_hot;
  logic signed [EW-1:0] r;

  always_comb begin
    ext     = {val[IN_WIDTH-1], val};
    one_hot = {{(EW-1){1'b0}}, 1'b1} << shift;
    rnd     = signed'(one_hot >> 1);
    r       = (ext + rnd) >>> shift;
    q       = r[DATA_WIDTH-1:0];
    sat     = 1'b0;
    if (r > RMAX) begin
      q   = DATA_WIDTH'(INT8_MAX);
      sat = 1'b1;
    end else if (r < RMIN) begin
      q   = DATA_WIDTH'(INT8_MIN);
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/requant_int8.sv
// Three-stage requantizer: bias add, scale multiply, round/shift/saturate to int8.
// One global advance enable stalls the whole pipe under output backpressure.
module requant_int8 #(
  parameter int ACC_WIDTH   = 32,
  parameter int MULT_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [ACC_WIDTH-1:0]  acc_in,
  input  logic signed [ACC_WIDTH-1:0]  bias_in,
  input  logic        [MULT_WIDTH-1:0] mult_in,
  input  logic       [SHIFT_WIDTH-1:0] shift_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         sat_out,
  output logic         [CNT_WIDTH-1:0] sat_count,
  input  logic                         sat_clr
);

  import cnn_pkg::*;

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int PROD_W = ACC_WIDTH + MULT_WIDTH + 1;

  logic                    adv;
  logic                    consumed;
  logic                    v1;
  logic                    v2;
  logic signed [SUM_W-1:0] sum1;
  logic   [MULT_WIDTH-1:0] mult1;
  logic  [SHIFT_WIDTH-1:0] shift1;
  logic signed [PROD_W-1:0] prod2;
  logic  [SHIFT_WIDTH-1:0] shift2;
  logic signed [DATA_WIDTH-1:0] rs_q;
  logic                    rs_sat;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign consumed = out_valid && out_ready;

  round_sat_int8 #(
    .IN_WIDTH    (PROD_W),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_round_sat (
    .val   (prod2),
    .shift (shift2),
    .q     (rs_q),
    .sat   (rs_sat)
  );

  // Valid bits advance every enabled cycle; payloads load only behind a valid beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      sum1      <= '0;
      mult1     <= '0;
      shift1    <= '0;
      prod2     <= '0;
      shift2    <= '0;
      data_out  <= '0;
      sat_out   <= 1'b0;
    end else if (adv) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      if (in_valid) begin
        sum1   <= SUM_W'(acc_in) + SUM_W'(bias_in);
        mult1  <= mult_in;
        shift1 <= shift_in;
      end
      if (v1) begin
        prod2  <= PROD_W'(sum1) * PROD_W'($signed({1'b0, mult1}));
        shift2 <= shift1;
      end
      if (v2) begin
        data_out <= rs_q;
        sat_out  <= rs_sat;
      end
    end
  end

  // Counts clipped beats actually taken downstream; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (consumed && sat_out && (sat_count != {CNT_WIDTH{1'b1}})) begin
      sat_count <= sat_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_requant_int8.sv
// Randomized and directed bench for requant_int8 against an arithmetic reference model.
// Expected beats are queued at input handshake and compared at output consumption.
module tb_requant_int8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] acc_in = '0;
  logic signed [31:0] bias_in = '0;
  logic        [15:0] mult_in = '0;
  logic         [4:0] shift_in = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed  [7:0] data_out;
  logic               sat_out;
  logic        [15:0] sat_count;
  logic               sat_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int d;
    bit s;
  } exp_t;

  exp_t expq[$];
  int   seen[$];
  int   exp_cnt = 0;
  bit   prev_stall = 1'b0;
  int   prev_data = 0;
  bit   prev_sat = 1'b0;
  bit   rnd_done = 1'b0;

  requant_int8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .acc_in    (acc_in),
    .bias_in   (bias_in),
    .mult_in   (mult_in),
    .shift_in  (shift_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sat_out   (sat_out),
    .sat_count (sat_count),
    .sat_clr   (sat_clr)
  );

  always #5 clk = ~clk;

  // Plain 64-bit arithmetic: add, scale, round half up, shift, clip.
  function automatic void ref_model(input longint acc, input longint bias, input longint mult,
                                    input int shift, output int d, output bit s);
    longint sum, prod, r;
    sum  = acc + bias;
    prod = sum * mult;
    if (shift == 0) r = prod;
    else            r = (prod + (longint'(1) <<< (shift - 1))) >>> shift;
    s = 1'b1;
    if (r > 127)       d = 127;
    else if (r < -128) d = -128;
    else begin
      d = int'(r);
      s = 1'b0;
    end
  endfunction

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    check("in_ready", in_ready, !out_valid || out_ready);
    check("sat_count", sat_count, exp_cnt);
    if (prev_stall) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", data_out, prev_data);
      check("stall_sat", sat_out, prev_sat);
    end
    if (!rst_n) begin
      expq.delete();
      exp_cnt    = 0;
      prev_stall = 1'b0;
    end else begin
      e.s = 1'b0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stale_beat: got data %0d expected no beat", data_out);
        end else begin
          e = expq.pop_front();
          check("data_out", data_out, e.d);
          check("sat_out", sat_out, e.s);
          seen.push_back(int'(data_out));
        end
      end
      if (sat_clr) exp_cnt = 0;
      else if (out_valid && out_ready && e.s && exp_cnt < 65535) exp_cnt++;
      if (in_valid && in_ready) begin
        ref_model(longint'(acc_in), longint'(bias_in), longint'(mult_in), int'(shift_in), e.d, e.s);
        expq.push_back(e);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = int'(data_out);
      prev_sat   = sat_out;
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [15:0] m, input logic [4:0] s);
    int n = 0;
    acc_in   = a;
    bias_in  = b;
    mult_in  = m;
    shift_in = s;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string name, input int expd, input bit exps, input int explat);
    int n = 1;
    while (!out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_data"}, data_out, expd);
    check({name, "_sat"}, sat_out, exps);
    if (explat > 0) check({name, "_latency"}, n, explat);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int d;
    bit s;
    $display("[TB] start");

    ref_model(100, 0, 1, 3, d, s);
    check("model_round", d, 13);
    ref_model(-1000, 0, 3, 5, d, s);
    check("model_neg_round", d, -94);
    ref_model(1000, 24, 1, 3, d, s);
    check("model_sat_hi", d + (s ? 1000 : 0), 1127);
    ref_model(-5000, 0, 1, 0, d, s);
    check("model_sat_lo", d, -128);

    idleCycles(2);
    check("reset_out_valid", out_valid, 0);
    check("reset_data_out", data_out, 0);
    check("reset_sat_out", sat_out, 0);
    check("reset_sat_count", sat_count, 0);
    rst_n = 1'b1;
    idleCycles(1);

    applyStimulus(100, 0, 1, 3);
    checkOutput("round", 13, 0, 3);
    applyStimulus(-1000, 0, 3, 5);
    checkOutput("neg_round", -94, 0, 3);
    applyStimulus(1000, 24, 1, 3);
    checkOutput("sat_hi", 127, 1, 3);
    check("sat_count_1", sat_count, 1);
    applyStimulus(-5000, 0, 1, 0);
    checkOutput("sat_lo", -128, 1, 3);
    check("sat_count_2", sat_count, 2);
    sat_clr = 1'b1;
    idleCycles(1);
    sat_clr = 1'b0;
    check("sat_clr", sat_count, 0);

    applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 16'h0000, 0);
    checkOutput("mult_zero", 0, 0, 3);
    applyStimulus(32'h7FFFFFFF, 32'h7FFFFFFF, 16'hFFFF, 0);
    checkOutput("max_operands", 127, 1, 3);

    // Backpressure: ready pattern 1,0,0 repeating while six beats stream in.
    seen.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) applyStimulus(8 * k, 0, 1, 3);
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = (c % 3 == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    idleCycles(4);
    check("bp_count", seen.size(), 6);
    for (int k = 0; k < 6 && k < seen.size(); k++) check("bp_order", seen[k], k);

    // Reset with three beats in flight.
    applyStimulus(800, 0, 1, 3);
    applyStimulus(1600, 0, 1, 3);
    applyStimulus(-800, 0, 1, 3);
    rst_n = 1'b0;
    idleCycles(1);
    rst_n = 1'b1;
    check("rst_mid_out_valid", out_valid, 0);
    check("rst_mid_sat_count", sat_count, 0);
    for (int i = 0; i < 5; i++) begin
      idleCycles(1);
      check("rst_no_stale", out_valid, 0);
    end
    applyStimulus(160, 0, 1, 3);
    checkOutput("post_reset", 20, 0, 3);

    // Randomized traffic with random backpressure and occasional counter clears.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idleCycles($urandom_range(0, 2));
          if ($urandom_range(0, 1) == 0)
            applyStimulus($urandom_range(0, 4000) - 2000, $urandom_range(0, 400) - 200,
                          16'($urandom_range(0, 8)), 5'($urandom_range(0, 31)));
          else
            applyStimulus($urandom, $urandom, 16'($urandom), 5'($urandom_range(0, 31)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          sat_clr   = ($urandom_range(0, 49) == 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
        sat_clr   = 1'b0;
      end
    join
    idleCycles(10);
    check("random_drained", expq.size(), 0);

    // Drive the counter into saturation with a continuous clipped stream.
    sat_clr = 1'b1;
    idleCycles(1);
    sat_clr  = 1'b0;
    acc_in   = 32'h7FFFFFFF;
    bias_in  = 32'h7FFFFFFF;
    mult_in  = 16'hFFFF;
    shift_in = 5'd0;
    in_valid = 1'b1;
    idleCycles(65540);
    in_valid = 1'b0;
    idleCycles(5);
    check("cnt_saturated", sat_count, 16'hFFFF);
    applyStimulus(-5000, 0, 1, 0);
    checkOutput("cnt_hold_beat", -128, 1, 3);
    check("cnt_hold", sat_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
